// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the multi-port register file.
// Build option: define REGFILE_BYPASS_EN to make a same-cycle WB write
// visible on the read ports (write-first). Undefined gives read-first.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_XLEN_DEFAULT = 32;
    localparam int RF_NREG_DEFAULT = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit RF_BYPASS = 1'b1;
`else
    localparam bit RF_BYPASS = 1'b0;
`endif

    // First entry the clear pass touches; entry 0 is skipped when hardwired.
    function automatic int unsigned rf_idx_init(input int zero_reg);
        return (zero_reg != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port. Handles the address
// mux, x0 forcing, gating to zero while in reset or clearing, and the
// optional write-first bypass (REGFILE_BYPASS_EN, via RF_BYPASS).
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEFAULT,
    parameter int NREG     = RF_NREG_DEFAULT,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                      rst,
    input  logic                      ready,
    input  logic [AW-1:0]             addr,
    input  logic [NREG-1:0][XLEN-1:0] mem,
    input  logic                      byp_en,
    input  logic [AW-1:0]             byp_addr,
    input  logic [XLEN-1:0]           byp_data,
    output logic [XLEN-1:0]           rd
);

    logic byp_hit;
    assign byp_hit = RF_BYPASS && byp_en && (byp_addr == addr);

    // Stored data is only exposed once the clear pass has finished.
    always_comb begin
        rd = '0;
        if (rst && ready) begin
            if (ZERO_REG != 0 && addr == '0)
                rd = '0;
            else if (byp_hit)
                rd = byp_data;
            else
                rd = mem[addr];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, one WB write port, NRD read
// ports, optional hardwired x0. The array carries no reset; a clear
// sequencer zeroes it one entry per edge after reset or clr_req.
// Build option: REGFILE_BYPASS_EN (see regfile_pkg).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEFAULT,
    parameter int NREG     = RF_NREG_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 ready,
    input  logic                 RegWriteW,
    input  logic [AW-1:0]        RdW,
    input  logic [XLEN-1:0]      ResultW,
    input  logic [NRD*AW-1:0]    A,
    output logic [NRD*XLEN-1:0]  RD
);

    localparam logic [AW:0] IDX_INIT = (AW+1)'(rf_idx_init(ZERO_REG));
    localparam logic [AW:0] IDX_LAST = (AW+1)'(NREG-1);

    rf_state_t                 state;
    logic [AW:0]               idx;
    logic [NREG-1:0][XLEN-1:0] mem;
    logic                      wr_en;

    // A WB write lands only in RF_READY and never on hardwired x0.
    assign wr_en = (state == RF_READY) && RegWriteW &&
                   !(ZERO_REG != 0 && RdW == '0);

    // Clear sequencer: reset or clr_req restarts one full pass over idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RF_CLEAR;
            idx   <= IDX_INIT;
            ready <= 1'b0;
        end else if (clr_req) begin
            state <= RF_CLEAR;
            idx   <= IDX_INIT;
            ready <= 1'b0;
        end else if (state == RF_CLEAR) begin
            idx <= idx + (AW+1)'(1);
            if (idx == IDX_LAST) begin
                state <= RF_READY;
                ready <= 1'b1;
            end
        end
    end

    // Storage: clear writes zero at idx, otherwise accept the WB write.
    // A clr_req edge drops both, so the restarted pass begins cleanly.
    always_ff @(posedge clk) begin
        if (!clr_req) begin
            if (state == RF_CLEAR)
                mem[idx[AW-1:0]] <= '0;
            else if (wr_en)
                mem[RdW] <= ResultW;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_read_port #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .ZERO_REG (ZERO_REG)
        ) u_rp (
            .rst      (rst),
            .ready    (ready),
            .addr     (A[i*AW +: AW]),
            .mem      (mem),
            .byp_en   (wr_en),
            .byp_addr (RdW),
            .byp_data (ResultW),
            .rd       (RD[i*XLEN +: XLEN])
        );
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the ID stage, successor to the fixed 32×32 two-port register file. It has one write port from WB, NRD combinational read ports, and optional hardwiring of x0. A built-in clear sequencer zeroes the array one entry per cycle after reset or on request, so the storage array needs no reset. Optional write-to-read bypass lets a WB write be seen by ID in the same cycle.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (1–4)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register
- AW (localparam), $clog2(NREG), address width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- clr_req  in  1  one-cycle pulse; restarts the clear sequence (soft reset)
- ready  out  1  high when the file accepts writes and returns stored data
- RegWriteW  in  1  write enable from WB
- RdW  in  AW  write address
- ResultW  in  XLEN  write data
- A  in  NRD*AW  read addresses; port i = A[i*AW +: AW]
- RD  out  NRD*XLEN  read data; port i = RD[i*XLEN +: XLEN]

## Operation
- States: RF_CLEAR, RF_READY. A clear index `idx` (AW+1 bits) walks the array.
- Reset asserted (rst=0):
  - state=RF_CLEAR, idx=ZERO_REG?1:0, ready=0.
  - All RD = 0 combinationally while rst=0.
- RF_CLEAR:
  - Each rising edge writes 0 to Register[idx], then idx+1.
  - On the edge that writes idx=NREG-1: go to RF_READY, ready=1.
  - RegWriteW is ignored and the write is dropped; WB must stall on !ready.
  - All RD = 0.
- RF_READY:
  - Each edge with RegWriteW=1 writes ResultW to Register[RdW].
  - If ZERO_REG=1 and RdW=0, the write is suppressed.
  - RD[i] = Register[A[i]] combinationally.
  - If ZERO_REG=1 and A[i]=0, RD[i]=0.
- clr_req=1 on an edge in either state: state=RF_CLEAR, idx reloaded, ready=0 from that edge onward. Any RegWriteW on the same edge is dropped.
- clr_req while already in RF_CLEAR restarts idx; the sequence is not extended past one full pass from the restart.
- Reads on different ports at the same address return identical data.

## Timing
- Read latency: 0 cycles (combinational from A and the array).
- Write latency: 1 edge; without bypass, visible on the cycle after the write edge.
- Clear duration: NREG-1 edges (ZERO_REG=1) or NREG edges (ZERO_REG=0) after rst deassertion or the clr_req edge. Default: ready rises after the 31st edge.
- Reset values: ready=0, all RD=0, state=RF_CLEAR. Array contents are undefined until the clear pass completes; they are never observable before then.
- Reset asserted mid-clear or mid-write: takes effect immediately (asynchronous); any in-flight write is lost.

## Configuration
- REGFILE_BYPASS_EN defined, in RF_READY: if RegWriteW=1, RdW=A[i], and the write is not suppressed (x0), then RD[i]=ResultW in the same cycle (write-first).
- REGFILE_BYPASS_EN undefined: RD[i] returns the pre-write array value during the write cycle (read-first). The pipeline covers this hazard with the forwarding unit.
- Bypass never applies in RF_CLEAR or while rst=0.

## Structure
- Package regfile_pkg:
  - `rf_state_t` enum {RF_CLEAR, RF_READY}
  - RF_XLEN_DEFAULT=32, RF_NREG_DEFAULT=32
  - `rf_idx_init(zero_reg)` function
- Sub-module regfile_read_port, instantiated NRD times by generate. Each instance handles:
  - address mux
  - x0 forcing
  - ready/rst gating
  - optional bypass compare
- The top level holds the array, the write logic and the clear FSM.

## Test plan
- Reset then clear: rst low 3 cycles, release. Count edges to ready=1: 31. Read all 32 addresses during and after clear: all return 0x00000000.
- Basic write/read: write x5=0xDEADBEEF. Next cycle A0=5, A1=5: both RD=0xDEADBEEF.
- x0 protection: write RdW=0, ResultW=0xFFFFFFFF. Read A0=0: RD=0. Repeat with ZERO_REG=0: RD=0xFFFFFFFF.
- Same-cycle read/write of x7 (old 0x1, new 0x2):
  - With REGFILE_BYPASS_EN: RD=0x2 in that cycle.
  - Without: RD=0x1, then 0x2 the next cycle.
- Soft clear: populate x1..x31 with nonzero values, pulse clr_req with RegWriteW=1 to x3=0xAA. ready drops that edge and returns after 31 edges. x3 and all other entries read 0.
- Async reset mid-clear: assert rst at idx=10. Outputs drop to 0 within the same cycle. On release, a full 31-edge pass restarts.
